// File: rtl/seg_addsub_unit.sv
// rtl/seg_addsub_unit.sv - multi-cycle add/subtract, SEG bits per clock LSB first, valid/ready on both sides
module seg_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NSEG = WIDTH / SEG;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, sum_r, sum_full;
    logic             sub_r, carry_r;
    logic [CW-1:0]    cnt;
    logic             cout_r, ovf_r, zero_r, neg_r;
    logic [SEG-1:0]   a_seg, b_seg;
    logic [SEG:0]     seg_res;
    logic             accept, last_seg, seg_ovf;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_seg  = (cnt == CW'(NSEG - 1));

    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = ovf_r;
    assign zero     = zero_r;
    assign negative = neg_r;

    // b is inverted for subtraction; the borrow-in is folded into the initial carry at accept
    always_comb begin
        a_seg    = a_r[int'(cnt)*SEG +: SEG];
        b_seg    = b_r[int'(cnt)*SEG +: SEG] ^ {SEG{sub_r}};
        seg_res  = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, carry_r};
        sum_full = sum_r;
        sum_full[int'(cnt)*SEG +: SEG] = seg_res[SEG-1:0];
        seg_ovf  = (a_seg[SEG-1] == b_seg[SEG-1]) && (seg_res[SEG-1] != a_seg[SEG-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_seg) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            cnt     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r     <= a;
                        b_r     <= b;
                        sub_r   <= sub;
                        carry_r <= cin ^ sub;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_r   <= sum_full;
                    carry_r <= seg_res[SEG];
                    cnt     <= cnt + CW'(1);
                    if (last_seg) begin
                        cout_r <= seg_res[SEG];
                        ovf_r  <= seg_ovf;
                        zero_r <= (sum_full == '0);
                        neg_r  <= sum_full[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_addsub_unit.sv
// tb/tb_seg_addsub_unit.sv - scoreboard bench for seg_addsub_unit (32/8, 16/4, 8/8)
module tb_seg_addsub_unit;

    typedef struct {
        longint unsigned sum;
        bit cout, ovf, zero, neg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cout, overflow, zero, negative;
    logic        rnd_rdy = 1'b0, rnd_bit = 1'b0, fixed_rdy = 1'b1;
    assign out_ready = rnd_rdy ? rnd_bit : fixed_rdy;

    logic        v16, r16, c16, sb16, ov16, or16, co16, ovf16, z16, n16;
    logic [15:0] a16, b16, sum16;
    logic        v8, r8, c8, sb8, ov8, or8, co8, ovf8, z8, n8;
    logic [7:0]  a8, b8, sum8;

    seg_addsub_unit #(.WIDTH(32), .SEG(8)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .overflow(overflow), .zero(zero), .negative(negative));

    seg_addsub_unit #(.WIDTH(16), .SEG(4)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
        .cin(c16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .cout(co16), .overflow(ovf16), .zero(z16), .negative(n16));

    seg_addsub_unit #(.WIDTH(8), .SEG(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .cin(c8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
        .cout(co8), .overflow(ovf8), .zero(z8), .negative(n8));

    int   nvec = 0, nerr = 0;
    int   cyc = 0, acc_cyc = 0;
    logic prev_ov = 1'b0, rdy_next = 1'b0;
    exp_t q[$];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: true integer arithmetic on the operands, then range tests for flags
    function automatic exp_t model(input int w, input longint unsigned ia, input longint unsigned ib,
                                   input bit ic, input bit is);
        exp_t e;
        longint unsigned m = (longint'(1) << w) - 1;
        longint sa, sb, r, lim;
        ia = ia & m;
        ib = ib & m;
        lim = longint'(1) << (w - 1);
        sa = ((ia >> (w - 1)) & 1) != 0 ? longint'(ia) - (longint'(1) << w) : longint'(ia);
        sb = ((ib >> (w - 1)) & 1) != 0 ? longint'(ib) - (longint'(1) << w) : longint'(ib);
        if (!is) begin
            e.sum  = (ia + ib + longint'(ic)) & m;
            e.cout = (ia + ib + longint'(ic)) > m;
            r      = sa + sb + longint'(ic);
        end else begin
            e.sum  = (ia - ib - longint'(ic)) & m;
            e.cout = ia >= ib + longint'(ic);
            r      = sa - sb - longint'(ic);
        end
        e.ovf  = (r >= lim) || (r < -lim);
        e.zero = (e.sum == 0);
        e.neg  = ((e.sum >> (w - 1)) & 1) != 0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1 rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares every presented result (including stall cycles) against the queue head
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_reset", in_ready, 0);
            prev_ov  <= 1'b0;
            rdy_next <= 1'b0;
        end else begin
            if (rdy_next) chk("in_ready_after_handshake", in_ready, 1);
            rdy_next <= 1'b0;
            if (in_valid && in_ready) acc_cyc <= cyc + 1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    if (!prev_ov) chk("latency", longint'(cyc - acc_cyc), 4);
                    chk("sum", sum, q[0].sum);
                    chk("cout", cout, q[0].cout);
                    chk("overflow", overflow, q[0].ovf);
                    chk("zero", zero, q[0].zero);
                    chk("negative", negative, q[0].neg);
                    chk("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        rdy_next <= 1'b1;
                    end
                end
            end
            prev_ov <= out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input bit ic, input bit is);
        int n = 0;
        a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 1, 0);
        q.push_back(model(32, ia, ib, ic, is));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 1, 0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input bit ic, input bit is);
        exp_t e;
        int n = 0;
        e = model(16, ia, ib, ic, is);
        a16 = ia; b16 = ib; c16 = ic; sb16 = is; v16 = 1'b1;
        chk("w16_in_ready", r16, 1);
        @(posedge clk);
        #1 v16 = 1'b0;
        while (!ov16 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("w16_latency", n, 4);
        chk("w16_sum", sum16, e.sum);
        chk("w16_cout", co16, e.cout);
        chk("w16_overflow", ovf16, e.ovf);
        chk("w16_zero", z16, e.zero);
        chk("w16_negative", n16, e.neg);
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input bit ic, input bit is);
        exp_t e;
        int n = 0;
        e = model(8, ia, ib, ic, is);
        a8 = ia; b8 = ib; c8 = ic; sb8 = is; v8 = 1'b1;
        chk("w8_in_ready", r8, 1);
        @(posedge clk);
        #1 v8 = 1'b0;
        while (!ov8 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("w8_latency", n, 1);
        chk("w8_sum", sum8, e.sum);
        chk("w8_cout", co8, e.cout);
        chk("w8_overflow", ovf8, e.ovf);
        chk("w8_zero", z8, e.zero);
        chk("w8_negative", n8, e.neg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0; sb16 = 1'b0; or16 = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sb8 = 1'b0; or8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, overflow, zero, negative}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // directed vectors with out_ready held high: out_valid must last one cycle
        issue(32'd2, 32'd6, 0, 0);                  drain();
        issue(32'hFFFF_FFFF, 32'd1, 0, 0);          drain();
        issue(32'h7FFF_FFFF, 32'd1, 0, 0);          drain();
        issue(32'd65535, 32'd65153, 0, 1);          drain();
        issue(32'd3, 32'd6, 0, 1);                  drain();
        issue(32'h8000_0000, 32'd1, 0, 1);          drain();
        issue(32'h0, 32'h0, 1, 1);                  drain();

        // backpressure: stall six cycles while hammering in_valid with new operands
        fixed_rdy = 1'b0;
        issue(32'h1234_5678, 32'h0FED_CBA9, 1, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 in_valid = ~in_valid;
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 in_valid = 1'b0; fixed_rdy = 1'b1;
        drain();
        issue(32'd1000, 32'd24, 0, 1);              drain();

        // reset while the counter holds 2
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_sum", sum, 0);
        chk("midrun_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        issue(32'd124, 32'd215, 0, 0);              drain();

        // randomized traffic with random consumer backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++)
            issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        rnd_rdy = 1'b0;

        run16(16'hFFFF, 16'h0001, 1, 0);
        run16(16'h8000, 16'h0001, 0, 1);
        for (int i = 0; i < 10; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        run8(8'd100, 8'd27, 0, 0);
        run8(8'd127, 8'd1, 0, 0);
        for (int i = 0; i < 10; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seg_addsub_unit.md
Name: seg_addsub_unit

Overview:
Parametrised, multi-cycle add/subtract unit for the ALU datapath. It is the successor to the combinational 32-bit adder/subtractor. It processes the operands SEG bits per clock, LSB segment first, with a registered carry between segments. This trades latency for a short carry chain. It adds valid/ready handshakes on input and output, and reports carry, signed overflow, zero and negative flags.

Parameters:
WIDTH, 32, operand/result width in bits
SEG, 8, bits processed per cycle; WIDTH must be a multiple of SEG; SEG >= 1
NSEG, WIDTH/SEG, derived segment count (localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  unit can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = A+B+cin, 1 = A-B-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result (mod 2^WIDTH)
cout  output  1  carry out of MSB (sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow
zero  output  1  sum == 0
negative  output  1  sum[WIDTH-1]

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); sampled only on the rising edge of clk.
- States: IDLE, RUN, DONE.
- Reset: state is IDLE, segment counter is 0, and all result registers (sum, cout, overflow, zero, negative) are 0. out_valid is 0. in_ready is 0 while rst is high.
- Reset mid-RUN or mid-DONE: the operation is abandoned and no result is presented. After reset the unit is immediately ready.
- in_ready = (state == IDLE) & ~rst. It is combinational from state only and never depends on in_valid.
- IDLE: on an edge where in_valid & in_ready:
  - latch a, b and sub;
  - set carry register = cin ^ sub;
  - clear counter;
  - go to RUN.
  - Otherwise stay in IDLE. Inputs are ignored outside IDLE.
- RUN: each cycle processes segment k = counter (bits k*SEG .. k*SEG+SEG-1):
  - {c, s} = a_seg + (b_seg ^ {SEG{sub}}) + carry;
  - write s into sum register segment k;
  - carry <= c;
  - counter increments.
- RUN, last segment (k == NSEG-1):
  - cout = final carry;
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - zero and negative are computed from the complete sum;
  - go to DONE.
- Latency: NSEG cycles. With acceptance at edge T, out_valid is high from edge T+NSEG onward.
- DONE: out_valid = 1. sum and all flags are held stable until the edge where out_valid & out_ready, then go to IDLE. in_ready rises the cycle after the handshake, so there is no same-cycle accept/return.
- sum/flags are only guaranteed while out_valid is high. The partial sum is not visible in a guaranteed form during RUN. Registers retain the last result after the handshake.
- out_ready held high before DONE: the handshake completes on the first DONE cycle, so out_valid is high exactly one cycle.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Subtraction: A + ~B + ~cin, i.e. initial carry = 1 when cin = 0.
- NSEG = 1 is legal: RUN lasts 1 cycle and latency is 1.
- Counter width is clog2(NSEG), minimum 1 bit.

Test Plan:
- WIDTH=32, SEG=8. Add a=2, b=6, cin=0.
  -> out_valid exactly 4 cycles after acceptance; sum=8, cout=0, overflow=0, zero=0, negative=0.
- Add a=0xFFFFFFFF, b=1, cin=0.
  -> sum=0, cout=1, zero=1, overflow=0.
- Add a=0x7FFFFFFF, b=1.
  -> sum=0x80000000, overflow=1, negative=1, cout=0.
- Subtract a=65535, b=65153, cin=0.
  -> sum=382, cout=1.
- Subtract a=3, b=6.
  -> sum=0xFFFFFFFD, cout=0, negative=1.
- Subtract a=0x80000000, b=1.
  -> sum=0x7FFFFFFF, overflow=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid; toggle in_valid with new operands meanwhile.
  -> sum/flags stable; in_ready=0; new operands ignored.
  -> On release: handshake, in_ready=1 the next cycle, next op correct.
- Assert rst for one cycle at RUN counter=2.
  -> next cycle: out_valid=0, sum=0, in_ready=1.
  -> A following add 124+215 returns 339.
- Second instance WIDTH=16, SEG=4: 0xFFFF+0x0001 with cin=1.
  -> sum=0x0001, cout=1, latency 4.
- Third instance WIDTH=8, SEG=8: 100+27.
  -> sum=127, latency 1.
